// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// A granted producer keeps the port until it sends a word flagged last.
module fifo_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 27,
    parameter int CNT_W   = 32
) (
    input  logic                       write_clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       fifo_full,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic                       fifo_write_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       locked,
    output logic [CNT_W-1:0]           word_count,
    output logic [CNT_W-1:0]           packet_count
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               locked_q, locked_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   sel_next;
    logic               grant_ok;
    logic               xfer;
    int                 scan_idx;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_idx);
            end else begin
                win_found = win_found;
            end
        end
    end

    // Port grant and zero-latency data path to the FIFO pins
    always_comb begin
        sel_idx  = (state_q == ST_LOCKED) ? owner_q : win_idx;
        sel_next = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
        grant_ok = !rst && !fifo_full &&
                   ((state_q == ST_LOCKED) || (enable && win_found));
        if (grant_ok) begin
            req_ready = NUM_REQ'(1) << sel_idx;
        end else begin
            req_ready = '0;
        end
        xfer             = |(req_valid & req_ready);
        fifo_write_valid = xfer;
        if (xfer) begin
            fifo_data_in = req_data[int'(sel_idx)*WIDTH +: WIDTH];
        end else begin
            fifo_data_in = '0;
        end
    end

    // Next-state: lock on a non-last word, release and advance rr_ptr on last
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        word_cnt_d = word_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (xfer) begin
            grant_d    = sel_idx;
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (req_last[sel_idx]) begin
                state_d   = ST_IDLE;
                rr_ptr_d  = sel_next;
                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            end else begin
                state_d = ST_LOCKED;
                owner_d = sel_idx;
            end
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State, pointers and statistics registers
    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            locked_q   <= 1'b0;
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            locked_q   <= locked_d;
            word_cnt_q <= word_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign grant_idx    = grant_q;
    assign locked       = locked_q;
    assign word_count   = word_cnt_q;
    assign packet_count = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed table-driven bench for fifo_write_arbiter with NUM_REQ=4, WIDTH=27.
module tb_fifo_write_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 27;
    localparam int CNT_W   = 32;

    logic                     write_clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     enable = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_last = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full = 1'b0;
    logic [WIDTH-1:0]         fifo_data_in;
    logic                     fifo_write_valid;
    logic [1:0]               grant_idx;
    logic                     locked;
    logic [CNT_W-1:0]         word_count;
    logic [CNT_W-1:0]         packet_count;

    int checks = 0;
    int failures = 0;

    fifo_write_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .write_clk(write_clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_data_in(fifo_data_in), .fifo_write_valid(fifo_write_valid),
        .grant_idx(grant_idx), .locked(locked),
        .word_count(word_count), .packet_count(packet_count)
    );

    always #5 write_clk = ~write_clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        full;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [26:0] d3, d2, d1, d0;
        logic [3:0]  exp_ready;
        logic        exp_wv;
        logic [26:0] exp_data;
        logic [1:0]  exp_grant;
        logic        exp_locked;
        logic [31:0] exp_wc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mkv(input logic r, input logic e, input logic f,
                                 input logic [3:0] v, input logic [3:0] l,
                                 input logic [26:0] d3, input logic [26:0] d2,
                                 input logic [26:0] d1, input logic [26:0] d0,
                                 input logic [3:0] rdy, input logic wv,
                                 input logic [26:0] dat, input logic [1:0] g,
                                 input logic lk, input logic [31:0] wc,
                                 input logic [31:0] pc);
        vec_t t;
        t.rst = r; t.en = e; t.full = f; t.valid = v; t.last = l;
        t.d3 = d3; t.d2 = d2; t.d1 = d1; t.d0 = d0;
        t.exp_ready = rdy; t.exp_wv = wv; t.exp_data = dat;
        t.exp_grant = g; t.exp_locked = lk; t.exp_wc = wc; t.exp_pc = pc;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        rst       = t.rst;
        enable    = t.en;
        fifo_full = t.full;
        req_valid = t.valid;
        req_last  = t.last;
        req_data  = {t.d3, t.d2, t.d1, t.d0};
    endtask

    initial begin
        // 1-5: single-word packets alternating 0 and 2, then req0 alone (rr_ptr -> 1)
        vecs[0]  = mkv(0,1,0,4'b0101,4'b0101,27'h3,27'h2,27'h11,27'h1, 4'b0001,1,27'h1, 2'd0,0,32'd1,32'd1);
        vecs[1]  = mkv(0,1,0,4'b0101,4'b0101,27'h3,27'h2,27'h11,27'h1, 4'b0100,1,27'h2, 2'd2,0,32'd2,32'd2);
        vecs[2]  = mkv(0,1,0,4'b0101,4'b0101,27'h3,27'h2,27'h11,27'h1, 4'b0001,1,27'h1, 2'd0,0,32'd3,32'd3);
        vecs[3]  = mkv(0,1,0,4'b0101,4'b0101,27'h3,27'h2,27'h11,27'h1, 4'b0100,1,27'h2, 2'd2,0,32'd4,32'd4);
        vecs[4]  = mkv(0,1,0,4'b0001,4'b0001,27'h3,27'h2,27'h11,27'h1, 4'b0001,1,27'h1, 2'd0,0,32'd5,32'd5);
        // 6-10: req1 three-word packet while req0/req3 wait, then 3, then 0
        vecs[5]  = mkv(0,1,0,4'b1011,4'b1001,27'h3,27'h2,27'hA,27'h1,  4'b0010,1,27'hA, 2'd1,1,32'd6,32'd5);
        vecs[6]  = mkv(0,1,0,4'b1011,4'b1001,27'h3,27'h2,27'hB,27'h1,  4'b0010,1,27'hB, 2'd1,1,32'd7,32'd5);
        vecs[7]  = mkv(0,1,0,4'b1011,4'b1011,27'h3,27'h2,27'hC,27'h1,  4'b0010,1,27'hC, 2'd1,0,32'd8,32'd6);
        vecs[8]  = mkv(0,1,0,4'b1001,4'b1001,27'h3,27'h2,27'h11,27'h1, 4'b1000,1,27'h3, 2'd3,0,32'd9,32'd7);
        vecs[9]  = mkv(0,1,0,4'b1001,4'b1001,27'h3,27'h2,27'h11,27'h1, 4'b0001,1,27'h1, 2'd0,0,32'd10,32'd8);
        // 11-16: req2 packet stalled by fifo_full for 4 cycles
        vecs[10] = mkv(0,1,0,4'b0100,4'b0000,27'h3,27'h20,27'h11,27'h1,4'b0100,1,27'h20,2'd2,1,32'd11,32'd8);
        for (int i = 11; i < 15; i++)
            vecs[i] = mkv(0,1,1,4'b0110,4'b0110,27'h3,27'h21,27'h11,27'h1,4'b0000,0,27'h0,2'd2,1,32'd11,32'd8);
        vecs[15] = mkv(0,1,0,4'b0100,4'b0100,27'h3,27'h21,27'h11,27'h1,4'b0100,1,27'h21,2'd2,0,32'd12,32'd9);
        // 17-23: enable drops during req1's packet; bubble; no new grants; resume at 2
        vecs[16] = mkv(0,1,0,4'b0010,4'b0000,27'h3,27'h2,27'h30,27'h1, 4'b0010,1,27'h30,2'd1,1,32'd13,32'd9);
        vecs[17] = mkv(0,0,0,4'b0010,4'b0000,27'h3,27'h2,27'h31,27'h1, 4'b0010,1,27'h31,2'd1,1,32'd14,32'd9);
        vecs[18] = mkv(0,0,0,4'b0000,4'b0010,27'h3,27'h2,27'h99,27'h1, 4'b0010,0,27'h0, 2'd1,1,32'd14,32'd9);
        vecs[19] = mkv(0,0,0,4'b0010,4'b0010,27'h3,27'h2,27'h32,27'h1, 4'b0010,1,27'h32,2'd1,0,32'd15,32'd10);
        vecs[20] = mkv(0,0,0,4'b1111,4'b1111,27'h3,27'h2,27'h11,27'h1, 4'b0000,0,27'h0, 2'd1,0,32'd15,32'd10);
        vecs[21] = mkv(0,0,0,4'b1111,4'b1111,27'h3,27'h2,27'h11,27'h1, 4'b0000,0,27'h0, 2'd1,0,32'd15,32'd10);
        vecs[22] = mkv(0,1,0,4'b1111,4'b1111,27'h3,27'h2,27'h11,27'h1, 4'b0100,1,27'h2, 2'd2,0,32'd16,32'd11);
        // 24-27: reset while locked on req3, restart from index 0, full while idle
        vecs[23] = mkv(0,1,0,4'b1000,4'b0000,27'h40,27'h2,27'h11,27'h1,4'b1000,1,27'h40,2'd3,1,32'd17,32'd11);
        vecs[24] = mkv(1,1,0,4'b1000,4'b0000,27'h40,27'h2,27'h11,27'h1,4'b0000,0,27'h0, 2'd0,0,32'd0,32'd0);
        vecs[25] = mkv(0,1,0,4'b1010,4'b1010,27'h51,27'h2,27'h50,27'h1,4'b0010,1,27'h50,2'd1,0,32'd1,32'd1);
        vecs[26] = mkv(0,1,1,4'b1111,4'b1111,27'h3,27'h2,27'h11,27'h1, 4'b0000,0,27'h0, 2'd1,0,32'd1,32'd1);

        // Reset with every requester valid: no ready, no write
        @(negedge write_clk);
        rst = 1'b1; enable = 1'b1; req_valid = 4'b1111; req_last = 4'b1111;
        req_data = {27'h3, 27'h2, 27'h11, 27'h1};
        #1;
        check("rst_ready", -1, 32'(req_ready), 32'd0);
        check("rst_wv",    -1, 32'(fifo_write_valid), 32'd0);
        check("rst_data",  -1, 32'(fifo_data_in), 32'd0);
        @(posedge write_clk); #1;
        check("rst_grant",  -1, 32'(grant_idx), 32'd0);
        check("rst_locked", -1, 32'(locked), 32'd0);
        check("rst_wc",     -1, word_count, 32'd0);
        check("rst_pc",     -1, packet_count, 32'd0);

        foreach (vecs[i]) begin
            @(negedge write_clk);
            apply(vecs[i]);
            #1;
            check("ready", i, 32'(req_ready), 32'(vecs[i].exp_ready));
            check("wv",    i, 32'(fifo_write_valid), 32'(vecs[i].exp_wv));
            check("data",  i, 32'(fifo_data_in), 32'(vecs[i].exp_data));
            @(posedge write_clk); #1;
            check("grant",  i, 32'(grant_idx), 32'(vecs[i].exp_grant));
            check("locked", i, 32'(locked), 32'(vecs[i].exp_locked));
            check("wc",     i, word_count, vecs[i].exp_wc);
            check("pc",     i, packet_count, vecs[i].exp_pc);
        end

        // word_count wrap: preload all-ones, one single-word write from req0
        @(negedge write_clk);
        fifo_full = 1'b0; req_valid = 4'b0000;
        force dut.word_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.word_cnt_q;
        req_valid = 4'b0001; req_last = 4'b0001;
        #1;
        check("wrap_pre",   100, word_count, 32'hFFFF_FFFF);
        check("wrap_ready", 100, 32'(req_ready), 32'h1);
        @(posedge write_clk); #1;
        check("wrap_wc",    100, word_count, 32'd0);
        check("wrap_pc",    100, packet_count, 32'd2);
        check("wrap_grant", 100, 32'(grant_idx), 32'd0);

        // rr_ptr now 1: with everyone valid, req1 wins next
        @(negedge write_clk);
        req_valid = 4'b1111; req_last = 4'b1111;
        #1;
        check("rr_ready", 101, 32'(req_ready), 32'h2);
        check("rr_data",  101, 32'(fifo_data_in), 32'h11);
        @(posedge write_clk); #1;
        check("rr_grant", 101, 32'(grant_idx), 32'd1);
        check("rr_wc",    101, word_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
